xz_resolve_buf: RTL
===================

XZ_RESOLVE_BUF -- requirements
Module: xz_resolve_buf

Interface
REQ-001 Parameter CH, default 4: number of driving channels, range 2..8.
REQ-002 Parameter W, default 8: data bits per channel, range 1..32.
REQ-003 Parameter DEPTH, default 4: FIFO entries, power of 2, range 2..16.
REQ-004 Parameter PULL, default 0: undriven-bit resolution; 0 gives 0 (tri0), 1 gives 1 (tri1), 2 gives Z (tri).
REQ-005 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 drv_en  input  CH  per-channel driver enable; a disabled channel counts as Z on every bit.
REQ-009 drv_data  input  CH*W*2  per-channel 4-state word, 2-bit code per bit: 00=0, 01=1, 10=Z, 11=X.
REQ-010 in_valid  input  1  sample request for the current drv_* values.
REQ-011 in_ready  output  1  sample acceptance; equals not full.
REQ-012 flush  input  1  synchronous FIFO clear.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  consumer accepts head entry.
REQ-015 out_data  output  W*2  resolved 4-state word at the head, same coding as REQ-009.
REQ-016 out_conflict  output  1  head word has at least one bit resolved to X by driver disagreement.
REQ-017 out_xz  output  1  head word has at least one bit equal to X or Z.
REQ-018 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 Per-bit resolution SHALL be combinational over enabled channels; non-Z drivers all 0 give 0, all 1 give 1, and no non-Z driver gives the PULL value.
REQ-020 A bit with both 0 and 1 drivers SHALL resolve to X and set the conflict flag.
REQ-021 A bit with any X driver SHALL resolve to X without setting the conflict flag.
REQ-022 A push SHALL occur when in_valid and in_ready are both high, storing the resolved word, the conflict flag and the xz flag.
REQ-023 A pop SHALL occur when out_valid and out_ready are both high.
REQ-024 A pushed word SHALL appear on out_data in the cycle after the push when the FIFO was empty (1-cycle latency), otherwise in FIFO order.
REQ-025 When the FIFO is full, in_ready SHALL be low; in_valid is then ignored, even if a pop occurs in the same cycle.
REQ-026 When the FIFO is empty, out_valid SHALL be low and out_ready SHALL be ignored.
REQ-027 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave count unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 flush SHALL set count to 0 and out_valid to 0 at the next edge, and SHALL override a push or pop in the same cycle.
REQ-030 out_data, out_conflict and out_xz SHALL be all-zero codes whenever out_valid is low.

Reset
REQ-031 rst_n low SHALL immediately clear the pointers, count, out_valid, out_data, out_conflict and out_xz to 0, and drive in_ready high after release.
REQ-032 An assertion of rst_n mid-stream SHALL discard all stored entries, with no partial output.

Configuration
REQ-033 Macro XZ_RESOLVE_BUF_STATS_EN SHALL add output conflict_cnt (16 bits), reset to 0, which increments on each push with the conflict flag set and saturates at 0xFFFF.
REQ-034 Without XZ_RESOLVE_BUF_STATS_EN, the port conflict_cnt and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-035 Stimulus: CH=4, W=8, PULL=0, only ch0 enabled with data 0xA5 encoded, one push. Response: out_data equals the 0xA5 code in the next cycle; out_conflict=0; out_xz=0.
REQ-036 Stimulus: ch0 drives bit0=0 and ch1 drives bit0=1, both enabled. Response: bit0=X; out_conflict=1; out_xz=1.
REQ-037 Stimulus: no channel enabled, with PULL=0, 1 and 2 in turn. Response: all bits are 0, 1 and Z respectively; out_xz=1 only for PULL=2.
REQ-038 Stimulus: DEPTH=4, 5 pushes with out_ready=0. Response: count=4 and in_ready=0; the 5th push is dropped; 4 pops return the words in order across the pointer wrap.
REQ-039 Stimulus: count=2, then push, pop and flush together. Response: count=0 and out_valid=0 on the next cycle.
REQ-040 Stimulus: with XZ_RESOLVE_BUF_STATS_EN, 70000 conflicting pushes interleaved with pops. Response: conflict_cnt=0xFFFF; rst_n low returns it to 0 immediately.

Source files
------------

// File: rtl/xz_resolve_buf.sv
// xz_resolve_buf
//   Resolves CH tri-state style drivers into one 4-state word per sample and
//   buffers the resolved words, with per-word conflict and X/Z flags, in a
//   DEPTH-entry FIFO.
//
//   4-state bit code (drv_data and out_data): 00=0, 01=1, 10=Z, 11=X.
//   Channel c, bit b lives at drv_data[(c*W+b)*2 +: 2].
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   drv_en        per-channel driver enable (disabled channel = Z)
//   drv_data      per-channel 4-state words
//   in_valid      sample request; push when in_valid && in_ready
//   in_ready      not full
//   flush         synchronous clear, wins over push/pop
//   out_valid     head entry valid
//   out_ready     consumer accepts head entry
//   out_data      resolved head word (all zero when out_valid is low)
//   out_conflict  head word had a driver disagreement on some bit
//   out_xz        head word holds at least one X or Z bit
//   count         FIFO occupancy
//   conflict_cnt  (only with XZ_RESOLVE_BUF_STATS_EN) saturating count of
//                 pushes carrying the conflict flag
//
// Optional feature macro: XZ_RESOLVE_BUF_STATS_EN
module xz_resolve_buf #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PULL  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH-1:0]           drv_en,
  input  logic [CH*W*2-1:0]       drv_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W*2-1:0]          out_data,
  output logic                    out_conflict,
  output logic                    out_xz,
`ifdef XZ_RESOLVE_BUF_STATS_EN
  output logic [15:0]             conflict_cnt,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * W + 2;  // {conflict, xz, word}

  localparam logic [1:0] PULL_CODE = (PULL == 1) ? 2'b01 :
                                     (PULL == 2) ? 2'b10 : 2'b00;

  // ---------------------------------------------------------------------
  // Combinational resolution
  // ---------------------------------------------------------------------
  logic [2*W-1:0] res_word;
  logic [W-1:0]   bit_conf;
  logic [W-1:0]   bit_xz;
  logic           res_conf;
  logic           res_xz;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic has0;
      logic has1;
      logic hasx;

      always_comb begin
        has0 = 1'b0;
        has1 = 1'b0;
        hasx = 1'b0;
        for (int c = 0; c < CH; c++) begin
          if (drv_en[c]) begin
            case (drv_data[(c*W+gi)*2 +: 2])
              2'b00:   has0 = 1'b1;
              2'b01:   has1 = 1'b1;
              2'b11:   hasx = 1'b1;
              default: ;  // Z driver contributes nothing
            endcase
          end
        end
      end

      // An X driver dominates and is not a disagreement, so it masks the
      // conflict flag for this bit even if 0 and 1 drivers are also present.
      assign res_word[gi*2 +: 2] = (hasx || (has0 && has1)) ? 2'b11 :
                                   has0                     ? 2'b00 :
                                   has1                     ? 2'b01 :
                                                              PULL_CODE;
      assign bit_conf[gi] = has0 & has1 & ~hasx;
      // Codes 10 (Z) and 11 (X) share the upper bit.
      assign bit_xz[gi]   = res_word[gi*2+1];
    end
  endgenerate

  assign res_conf = |bit_conf;
  assign res_xz   = |bit_xz;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Pointers are exactly AW bits wide and DEPTH is a power of two, so the
  // increments wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: every output is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {res_conf, res_xz, res_word};
  end

  assign head         = mem[rd_ptr_reg];
  assign out_data     = out_valid ? head[2*W-1:0] : '0;
  assign out_conflict = out_valid & head[EW-1];
  assign out_xz       = out_valid & head[EW-2];
  assign count        = count_reg;

`ifdef XZ_RESOLVE_BUF_STATS_EN
  logic [15:0] conflict_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_reg <= '0;
    end else if (push && res_conf && (conflict_cnt_reg != 16'hFFFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule
